// File: rtl/alu_extra_seq.sv
// Multi-cycle RV32I extra-ALU stage: ADD/SUB in one cycle, SLL/SRL/SRA through an
// iterative shifter moving STEP bits per cycle, with valid/ready handshakes on both sides.
module alu_extra_seq #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        funct3,
   input  logic              alt,
   input  logic [XLEN-1:0]   operand_a,
   input  logic [XLEN-1:0]   operand_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              illegal
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_e;

   localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

   state_e               state_q, state_d;
   shop_e                shop_q, shop_d;
   logic [XLEN-1:0]      work_q, work_d;
   logic [SHAMT_W-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic                 illegal_q, illegal_d;

   logic [SHAMT_W-1:0]   shamt;
   logic [SHAMT_W-1:0]   step_k;
   logic [XLEN-1:0]      shifted;

   // Arithmetic shift keeps the MSB, so the original sign is refilled every step.
   function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                                input shop_e op,
                                                input logic [SHAMT_W-1:0] k);
      logic [XLEN-1:0] r;
      case (op)
         SH_LL:   r = v << k;
         SH_RL:   r = v >> k;
         default: r = $signed(v) >>> k;
      endcase
      return r;
   endfunction

   assign shamt   = operand_b[SHAMT_W-1:0];
   assign step_k  = (rem_q > STEP_K) ? STEP_K : rem_q;
   assign shifted = shift_by(work_q, shop_q, step_k);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         shop_q    <= SH_LL;
         work_q    <= '0;
         rem_q     <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shop_q    <= shop_d;
         work_q    <= work_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shop_d    = shop_q;
      work_d    = work_q;
      rem_d     = rem_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               case (funct3)
                  3'd0: begin
                     result_d  = alt ? (operand_a - operand_b) : (operand_a + operand_b);
                     illegal_d = 1'b0;
                     state_d   = S_DONE;
                  end
                  3'd1, 3'd5: begin
                     shop_d    = (funct3 == 3'd1) ? SH_LL : (alt ? SH_RA : SH_RL);
                     illegal_d = 1'b0;
                     if (shamt == '0) begin
                        result_d = operand_a;
                        state_d  = S_DONE;
                     end else begin
                        work_d  = operand_a;
                        rem_d   = shamt;
                        state_d = S_SHIFT;
                     end
                  end
                  default: begin
                     result_d  = '0;
                     illegal_d = 1'b1;
                     state_d   = S_DONE;
                  end
               endcase
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - step_k;
            if (rem_q == step_k) begin
               result_d = shifted;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      result    = result_q;
      illegal   = illegal_q;
   end

endmodule

// File: tb/tb_alu_extra_seq.sv
// Directed bench for alu_extra_seq: handshakes, shift latency, backpressure, reset abort.
module tb_alu_extra_seq;

   localparam int XLEN = 32;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      funct3 = 3'd0;
   logic            alt = 1'b0;
   logic [XLEN-1:0] operand_a = '0;
   logic [XLEN-1:0] operand_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_extra_seq #(.XLEN(32), .SHAMT_W(5), .STEP(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .alt       (alt),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   // Present one op for a single accepting edge; returns at the negedge after acceptance.
   task automatic issue(input logic [2:0] f3, input logic al,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(negedge clock);
      funct3 = f3; alt = al; operand_a = a; operand_b = b; in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // Cycles from acceptance until out_valid is seen (capped at 100).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++;
      if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", result); end
      n_checks++;
      if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_sub();
      int lat;
      issue(3'd0, 1'b1, 32'd5, 32'd7);
      wait_valid(lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL sub_latency got=%0d exp=1", lat); end
      n_checks++;
      if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result got=%h exp=fffffffe", result); end
      n_checks++;
      if (illegal !== 1'b0) begin n_fail++; $display("FAIL sub_illegal got=%b exp=0", illegal); end
      consume();
   endtask

   task automatic test_sra();
      int lat;
      issue(3'd5, 1'b1, 32'h8000_0000, 32'd4);
      wait_valid(lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL sra_latency got=%0d exp=2", lat); end
      n_checks++;
      if (result !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_result got=%h exp=f8000000", result); end
      consume();
      issue(3'd5, 1'b1, 32'h8000_0010, 32'd6);
      wait_valid(lat);
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL sra6_latency got=%0d exp=3", lat); end
      n_checks++;
      if (result !== 32'hFE00_0000) begin n_fail++; $display("FAIL sra6_result got=%h exp=fe000000", result); end
      consume();
   endtask

   task automatic test_shift_edges();
      int lat;
      issue(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd31);
      wait_valid(lat);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL srl31_latency got=%0d exp=9", lat); end
      n_checks++;
      if (result !== 32'h0000_0001) begin n_fail++; $display("FAIL srl31_result got=%h exp=00000001", result); end
      consume();
      issue(3'd1, 1'b1, 32'h0000_0001, 32'h0000_0021);
      wait_valid(lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL sll_mask_latency got=%0d exp=2", lat); end
      n_checks++;
      if (result !== 32'h0000_0002) begin n_fail++; $display("FAIL sll_mask_result got=%h exp=00000002", result); end
      consume();
      issue(3'd1, 1'b0, 32'h1234_5678, 32'h0000_0040);
      wait_valid(lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL shift0_latency got=%0d exp=1", lat); end
      n_checks++;
      if (result !== 32'h1234_5678) begin n_fail++; $display("FAIL shift0_result got=%h exp=12345678", result); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      issue(3'd0, 1'b0, 32'd10, 32'd20);
      wait_valid(lat);
      funct3 = 3'd0; alt = 1'b0; operand_a = 32'd100; operand_b = 32'd200; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_checks++;
         if (result !== 32'd30 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold cyc=%0d result=%h in_ready=%b out_valid=%b exp result=0000001e in_ready=0 out_valid=1",
                     i, result, in_ready, out_valid);
         end
      end
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || result !== 32'd300) begin
         n_fail++; $display("FAIL bp_next out_valid=%b result=%h exp 1/0000012c", out_valid, result);
      end
      consume();
   endtask

   task automatic test_reset_midshift();
      int seen;
      issue(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd31);
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || result !== 32'h0) begin
         n_fail++; $display("FAIL abort_outputs out_valid=%b result=%h exp 0/00000000", out_valid, result);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (out_valid !== 1'b0 || result !== 32'h0) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL abort_stale got=%0d cycles with output exp=0", seen); end
   endtask

   task automatic test_illegal_add();
      int lat;
      issue(3'd2, 1'b0, 32'd5, 32'd6);
      wait_valid(lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
      n_checks++;
      if (illegal !== 1'b1 || result !== 32'h0) begin
         n_fail++; $display("FAIL illegal_flags illegal=%b result=%h exp 1/00000000", illegal, result);
      end
      consume();
      issue(3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_valid(lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL add_wrap_latency got=%0d exp=1", lat); end
      n_checks++;
      if (illegal !== 1'b0 || result !== 32'h0) begin
         n_fail++; $display("FAIL add_wrap illegal=%b result=%h exp 0/00000000", illegal, result);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_sub();
      test_sra();
      test_shift_edges();
      test_backpressure();
      test_reset_midshift();
      test_illegal_add();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
